// File: rtl/irq_pkg.sv
// Shared CSR addresses, interrupt bit positions, cause codes and FSM encoding
// for the hart interrupt controller (HART_IRQ_MEIP_EN enables the MEI source).
package irq_pkg;

    localparam logic [11:0] CSR_MIE = 12'h304;
    localparam logic [11:0] CSR_MIP = 12'h344;

    localparam int MSI_BIT = 3;
    localparam int MTI_BIT = 7;
    localparam int MEI_BIT = 11;

    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

`ifdef HART_IRQ_MEIP_EN
    localparam logic [31:0] IRQ_MASK = 32'h0000_0888;
`else
    localparam logic [31:0] IRQ_MASK = 32'h0000_0088;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACTIVE,
        ST_HOLD
    } irq_state_e;

    typedef struct packed {
        logic mei;
        logic msi;
        logic mti;
    } irq_vec_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: eligible sources -> valid flag and mcause value.
// Priority is MEI > MSI > MTI.
module irq_prio_enc
    import irq_pkg::*;
(
    input  irq_vec_t    elig_i,
    output logic        valid_o,
    output logic [31:0] cause_o
);

    // Pick the highest-priority eligible source; arms are mutually exclusive
    always_comb begin
        valid_o = 1'b1;
        cause_o = '0;
        unique case (1'b1)
            elig_i.mei: cause_o = CAUSE_MEI;
            (elig_i.msi && !elig_i.mei): cause_o = CAUSE_MSI;
            (elig_i.mti && !elig_i.msi && !elig_i.mei): cause_o = CAUSE_MTI;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/hart_irq_ctrl.sv
// Machine-mode interrupt controller: mip/mie CSRs, priority select, trap FSM.
// Define HART_IRQ_MEIP_EN to add the external interrupt (w_meip, bit 11).
module hart_irq_ctrl
    import irq_pkg::*;
#(
    parameter int HOLDOFF = 0
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        w_mtip,
    input  logic        w_msip,
`ifdef HART_IRQ_MEIP_EN
    input  logic        w_meip,
`endif
    input  logic        w_mstatus_mie,
    input  logic        w_csr_we,
    input  logic [11:0] w_csr_addr,
    input  logic [31:0] w_csr_wdata,
    output logic [31:0] w_csr_rdata,
    output logic        w_irq_req,
    output logic [31:0] w_irq_cause,
    input  logic        w_irq_ack,
    input  logic        w_mret
);

    irq_state_e  state_q;
    logic [31:0] mip_q, mip_d;
    logic [31:0] mie_q;
    logic [3:0]  cnt_q;
    logic        req_q;
    logic [31:0] cause_q;
    irq_vec_t    elig;
    logic        enc_valid;
    logic [31:0] enc_cause;

    // Pending bits sampled straight from the interrupt lines
    always_comb begin
        mip_d = '0;
        mip_d[MTI_BIT] = w_mtip;
        mip_d[MSI_BIT] = w_msip;
`ifdef HART_IRQ_MEIP_EN
        mip_d[MEI_BIT] = w_meip;
`endif
    end

    // mip follows the lines; mie keeps only implemented enable bits
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            mip_q <= '0;
            mie_q <= '0;
        end else begin
            mip_q <= mip_d;
            if (w_csr_we && w_csr_addr == CSR_MIE)
                mie_q <= w_csr_wdata & IRQ_MASK;
        end
    end

    // CSR read port, unknown addresses read zero
    always_comb begin
        case (w_csr_addr)
            CSR_MIE: w_csr_rdata = mie_q;
            CSR_MIP: w_csr_rdata = mip_q;
            default: w_csr_rdata = '0;
        endcase
    end

    // Eligible sources gated by the global enable
    always_comb begin
        elig.mei = mip_q[MEI_BIT] & mie_q[MEI_BIT] & w_mstatus_mie;
        elig.msi = mip_q[MSI_BIT] & mie_q[MSI_BIT] & w_mstatus_mie;
        elig.mti = mip_q[MTI_BIT] & mie_q[MTI_BIT] & w_mstatus_mie;
    end

    irq_prio_enc u_prio (
        .elig_i  (elig),
        .valid_o (enc_valid),
        .cause_o (enc_cause)
    );

    // Trap handshake FSM with registered request/cause and mret holdoff
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            cause_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enc_valid) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                        cause_q <= enc_cause;
                    end
                end
                ST_REQ: begin
                    if (w_irq_ack) begin
                        state_q <= ST_ACTIVE;
                        req_q   <= 1'b0;
                    end else if (!enc_valid) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_mret) begin
                        if (HOLDOFF == 0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_HOLD;
                            cnt_q   <= 4'(HOLDOFF);
                        end
                    end
                end
                ST_HOLD: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign w_irq_req   = req_q;
    assign w_irq_cause = cause_q;

endmodule

// File: tb/tb_hart_irq_ctrl.sv
// Directed bench for hart_irq_ctrl (HOLDOFF=3) with an expected-value queue.
// Works with or without HART_IRQ_MEIP_EN defined.
module tb_hart_irq_ctrl;

    logic        CLK = 1'b0;
    logic        RST_X;
    logic        w_mtip, w_msip, w_mstatus_mie;
    logic        w_csr_we;
    logic [11:0] w_csr_addr;
    logic [31:0] w_csr_wdata, w_csr_rdata;
    logic        w_irq_req;
    logic [31:0] w_irq_cause;
    logic        w_irq_ack, w_mret;
`ifdef HART_IRQ_MEIP_EN
    logic        w_meip;
    localparam logic [31:0] MASK = 32'h888;
`else
    localparam logic [31:0] MASK = 32'h088;
`endif

    hart_irq_ctrl #(.HOLDOFF(3)) dut (
        .CLK           (CLK),
        .RST_X         (RST_X),
        .w_mtip        (w_mtip),
        .w_msip        (w_msip),
`ifdef HART_IRQ_MEIP_EN
        .w_meip        (w_meip),
`endif
        .w_mstatus_mie (w_mstatus_mie),
        .w_csr_we      (w_csr_we),
        .w_csr_addr    (w_csr_addr),
        .w_csr_wdata   (w_csr_wdata),
        .w_csr_rdata   (w_csr_rdata),
        .w_irq_req     (w_irq_req),
        .w_irq_cause   (w_irq_cause),
        .w_irq_ack     (w_irq_ack),
        .w_mret        (w_mret)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   ncomp = 0;
    int   nfail = 0;

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        ncomp++;
        if (sbq.size() == 0) begin
            nfail++;
            $error("FAIL sb_empty observed=%h expected=queued_entry", obs);
            return;
        end
        e = sbq.pop_front();
        assert (obs === e.val) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        w_csr_we    = 1'b1;
        w_csr_addr  = a;
        w_csr_wdata = d;
        tick();
        w_csr_we    = 1'b0;
    endtask

    task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
        w_csr_addr = a;
        #1;
        d = w_csr_rdata;
    endtask

    logic [31:0] rd;

    initial begin
        RST_X = 1'b0;
        w_mtip = 0; w_msip = 0; w_mstatus_mie = 0;
        w_csr_we = 0; w_csr_addr = '0; w_csr_wdata = '0;
        w_irq_ack = 0; w_mret = 0;
`ifdef HART_IRQ_MEIP_EN
        w_meip = 0;
`endif
        #1;
        push("rst_req", 32'd0);   pop_chk({31'd0, w_irq_req});
        push("rst_cause", 32'd0); pop_chk(w_irq_cause);
        csr_rd(12'h304, rd);
        push("rst_mie", 32'd0);   pop_chk(rd);
        csr_rd(12'h344, rd);
        push("rst_mip", 32'd0);   pop_chk(rd);
        @(negedge CLK);
        RST_X = 1'b1;
        tick();

        // mie write masking and one-cycle write latency
        w_csr_we = 1'b1; w_csr_addr = 12'h304; w_csr_wdata = 32'hFFFF_FFFF;
        #1;
        push("mie_pre", 32'd0);   pop_chk(w_csr_rdata);
        tick();
        w_csr_we = 1'b0;
        csr_rd(12'h304, rd);
        push("mie_mask", MASK);   pop_chk(rd);
        csr_wr(12'h344, 32'hFFFF_FFFF);
        csr_rd(12'h344, rd);
        push("mip_ro", 32'd0);    pop_chk(rd);
        csr_rd(12'h300, rd);
        push("unk_addr", 32'd0);  pop_chk(rd);

        // timer path: two-cycle request latency
        csr_wr(12'h304, 32'h80);
        w_mstatus_mie = 1'b1;
        w_mtip = 1'b1;
        push("tmr_req_n0", 32'd0);
        push("tmr_req_n1", 32'd0);
        push("tmr_mip", 32'h80);
        push("tmr_req_n2", 32'd1);
        push("tmr_cause", 32'h8000_0007);
        pop_chk({31'd0, w_irq_req});
        tick();
        pop_chk({31'd0, w_irq_req});
        csr_rd(12'h344, rd);
        pop_chk(rd);
        tick();
        pop_chk({31'd0, w_irq_req});
        pop_chk(w_irq_cause);

        // ack, then mret into a 3-cycle holdoff with MTI still pending
        w_irq_ack = 1'b1;
        tick();
        w_irq_ack = 1'b0;
        push("ack_req", 32'd0);   pop_chk({31'd0, w_irq_req});
        w_mret = 1'b1;
        tick();
        w_mret = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push($sformatf("hold_req%0d", i), 32'd0);
            pop_chk({31'd0, w_irq_req});
            tick();
        end
        push("hold_rearm", 32'd1);    pop_chk({31'd0, w_irq_req});
        push("hold_cause", 32'h8000_0007); pop_chk(w_irq_cause);
        w_irq_ack = 1'b1;
        tick();
        w_irq_ack = 1'b0;
        w_mtip = 1'b0;
        w_mret = 1'b1;
        tick();
        w_mret = 1'b0;
        repeat (5) tick();

        // priority: MSI beats MTI, cause frozen while in REQ
        csr_wr(12'h304, 32'hFFFF_FFFF);
        w_msip = 1'b1;
        w_mtip = 1'b1;
        tick(); tick();
        push("prio_req", 32'd1);          pop_chk({31'd0, w_irq_req});
        push("prio_cause", 32'h8000_0003); pop_chk(w_irq_cause);
`ifdef HART_IRQ_MEIP_EN
        w_meip = 1'b1;
        tick(); tick();
        push("freeze_cause", 32'h8000_0003); pop_chk(w_irq_cause);
        w_meip = 1'b0;
        tick(); tick();
`endif

        // withdraw when eligibility is lost without ack
        w_msip = 1'b0;
        w_mtip = 1'b0;
        tick();
        push("wd_req1", 32'd1);   pop_chk({31'd0, w_irq_req});
        tick();
        push("wd_req2", 32'd0);   pop_chk({31'd0, w_irq_req});
        push("wd_cause", 32'h8000_0003); pop_chk(w_irq_cause);

        // ack wins over simultaneous loss of eligibility
        w_msip = 1'b1;
        tick(); tick();
        push("ackw_req", 32'd1);  pop_chk({31'd0, w_irq_req});
        w_msip = 1'b0;
        tick();
        push("ackw_hold", 32'd1); pop_chk({31'd0, w_irq_req});
        w_irq_ack = 1'b1;
        tick();
        w_irq_ack = 1'b0;
        push("ackw_drop", 32'd0); pop_chk({31'd0, w_irq_req});
        w_msip = 1'b1;
        tick(); tick(); tick();
        push("active_noreq", 32'd0); pop_chk({31'd0, w_irq_req});
        w_mret = 1'b1;
        tick();
        w_mret = 1'b0;
        repeat (3) tick();
        push("hold2_end", 32'd0); pop_chk({31'd0, w_irq_req});
        tick();
        push("rearm2", 32'd1);    pop_chk({31'd0, w_irq_req});
        push("rearm2_cause", 32'h8000_0003); pop_chk(w_irq_cause);

        // asynchronous reset in REQ
        RST_X = 1'b0;
        #1;
        push("arst_req", 32'd0);   pop_chk({31'd0, w_irq_req});
        push("arst_cause", 32'd0); pop_chk(w_irq_cause);
        @(negedge CLK);
        RST_X = 1'b1;
        tick();
        csr_rd(12'h304, rd);
        push("arst_mie", 32'd0);   pop_chk(rd);
        tick(); tick();
        push("arst_noreq", 32'd0); pop_chk({31'd0, w_irq_req});

        if (sbq.size() != 0) begin
            ncomp++;
            nfail++;
            $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
